// File: rtl/aes_spi_master.sv
// SPI mode-0 master: shifts one {data, key_len, key} frame out on mosi while capturing miso.
// Optional macro AES_SPI_READBACK_EN appends an automatic all-zero frame and takes result from it.
module aes_spi_master #(
   parameter int unsigned FRAME_W = 392,
   parameter int unsigned CLK_DIV = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] data_in,
   input  logic [255:0] key_in,
   input  logic [7:0]   key_len,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [127:0] result,
   output logic         cs,
   output logic         sclk,
   output logic         mosi,
   input  logic         miso
);
   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [8:0] BIT_LAST = 9'(FRAME_W - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

   state_e             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [8:0]         bit_q, bit_d;
   logic [FRAME_W-1:0] tx_q, tx_d;
   logic [FRAME_W-1:0] rx_q, rx_d;
   logic               sclk_q, sclk_d;
   logic               cs_q, cs_d;
   logic               mosi_q, mosi_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [127:0]       result_q, result_d;
`ifdef AES_SPI_READBACK_EN
   logic               second_q, second_d;
`endif
   logic               key_ok;
   logic               phase_end;

   assign key_ok = (key_len == 8'd16) || (key_len == 8'd24) || (key_len == 8'd32);

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      bit_d    = bit_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      sclk_d   = sclk_q;
      cs_d     = cs_q;
      mosi_d   = mosi_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      result_d = result_q;
`ifdef AES_SPI_READBACK_EN
      second_d = second_q;
`endif
      phase_end = (div_q == DIV_LAST);
      // Every non-idle state is built from CLK_DIV-cycle phases.
      if (state_q != StIdle) begin
         div_d = phase_end ? '0 : div_q + 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               if (key_ok) begin
                  state_d = StSetup;
                  tx_d    = {data_in, key_len, key_in};
                  mosi_d  = data_in[127];
                  cs_d    = 1'b0;
                  busy_d  = 1'b1;
                  bit_d   = '0;
                  div_d   = '0;
`ifdef AES_SPI_READBACK_EN
                  second_d = 1'b0;
`endif
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StSetup: begin
            if (phase_end) begin
               state_d = StShift;
               sclk_d  = 1'b1;
               rx_d    = {rx_q[FRAME_W-2:0], miso};
               bit_d   = '0;
            end
         end
         StShift: begin
            if (phase_end) begin
               if (sclk_q) begin
                  sclk_d = 1'b0;
                  tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
                  mosi_d = tx_q[FRAME_W-2];
               end else if (bit_q == BIT_LAST) begin
                  state_d = StHold;
                  cs_d    = 1'b1;
                  mosi_d  = 1'b0;
               end else begin
                  // bit_q counts rising edges already issued, minus one.
                  bit_d  = bit_q + 9'd1;
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[FRAME_W-2:0], miso};
               end
            end
         end
         StHold: begin
            if (phase_end) begin
`ifdef AES_SPI_READBACK_EN
               if (!second_q) begin
                  second_d = 1'b1;
                  state_d  = StSetup;
                  tx_d     = '0;
                  mosi_d   = 1'b0;
                  cs_d     = 1'b0;
               end else
`endif
               begin
                  state_d  = StIdle;
                  done_d   = 1'b1;
                  busy_d   = 1'b0;
                  result_d = rx_q[FRAME_W-1-:128];
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StIdle;
         div_q    <= '0;
         bit_q    <= '0;
         tx_q     <= '0;
         rx_q     <= '0;
         sclk_q   <= 1'b0;
         cs_q     <= 1'b1;
         mosi_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
`ifdef AES_SPI_READBACK_EN
         second_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         sclk_q   <= sclk_d;
         cs_q     <= cs_d;
         mosi_q   <= mosi_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         result_q <= result_d;
`ifdef AES_SPI_READBACK_EN
         second_q <= second_d;
`endif
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;
   assign result = result_q;
   assign cs     = cs_q;
   assign sclk   = sclk_q;
   assign mosi   = mosi_q;

endmodule
